// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Holds the state encodings, RV32I major opcodes, the instruction class codes
// produced by mc_opdecode, and the datapath mux-select / ALU-op encodings.
package mc_pkg;

    // Main FSM states
    localparam int unsigned StateW = 5;

    localparam logic [4:0] StFetch    = 5'd0;
    localparam logic [4:0] StDecode   = 5'd1;
    localparam logic [4:0] StMemAdr   = 5'd2;
    localparam logic [4:0] StMemRead  = 5'd3;
    localparam logic [4:0] StMemWb    = 5'd4;
    localparam logic [4:0] StMemWrite = 5'd5;
    localparam logic [4:0] StExecR    = 5'd6;
    localparam logic [4:0] StExecI    = 5'd7;
    localparam logic [4:0] StLui      = 5'd8;
    localparam logic [4:0] StAuipc    = 5'd9;
    localparam logic [4:0] StJal      = 5'd10;
    localparam logic [4:0] StJalr     = 5'd11;
    localparam logic [4:0] StLink     = 5'd12;
    localparam logic [4:0] StAluWb    = 5'd13;
    localparam logic [4:0] StBranch   = 5'd14;
    localparam logic [4:0] StHalt     = 5'd15;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Instruction classes used by the DECODE dispatch
    typedef logic [3:0] iclass_t;

    localparam iclass_t ClsMem     = 4'd0;  // load or store, split on opcode[5] later
    localparam iclass_t ClsRtype   = 4'd1;
    localparam iclass_t ClsItype   = 4'd2;
    localparam iclass_t ClsJal     = 4'd3;
    localparam iclass_t ClsJalr    = 4'd4;
    localparam iclass_t ClsBranch  = 4'd5;
    localparam iclass_t ClsLui     = 4'd6;
    localparam iclass_t ClsAuipc   = 4'd7;
    localparam iclass_t ClsFence   = 4'd8;
    localparam iclass_t ClsSystem  = 4'd9;
    localparam iclass_t ClsIllegal = 4'd10;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARegA  = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SrcBRegB  = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    // Result bus select
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    // ALU operation class handed to alu_control
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier for the multicycle control FSM.
// Ports:
//   opcode  in  7  IR[6:0]
//   iclass  out 4  instruction class (mc_pkg Cls* codes)
//   illegal out 1  opcode is not a recognised RV32I major opcode
module mc_opdecode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        iclass  = ClsIllegal;
        illegal = 1'b0;
        case (opcode)
            OpLoad,
            OpStore:  iclass = ClsMem;
            OpReg:    iclass = ClsRtype;
            OpImm:    iclass = ClsItype;
            OpJal:    iclass = ClsJal;
            OpJalr:   iclass = ClsJalr;
            OpBranch: iclass = ClsBranch;
            OpLui:    iclass = ClsLui;
            OpAuipc:  iclass = ClsAuipc;
            OpFence:  iclass = ClsFence;
            OpSystem: iclass = ClsSystem;
            default: begin
                iclass  = ClsIllegal;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32I datapath with a shared
// instruction/data memory. Sequences FETCH/DECODE/execute states, drives the
// mux selects and write enables each cycle and stalls on mem_ready.
// Ports:
//   clk, reset             clock (rising edge), async active-low reset
//   opcode                 IR[6:0], valid from DECODE onward
//   br_cond                branch comparator result, used in BRANCH
//   mem_ready              memory completes the current request this cycle
//   mem_req, mem_we        memory request / store strobe
//   adr_src                memory address select (0 = PC, 1 = result bus)
//   ir_write, pc_we        IR/OldPC latch enable, PC load enable
//   reg_we                 register file write enable
//   alu_src_a, alu_src_b   ALU operand selects
//   result_src, alu_op     result bus select, ALU operation class
//   retire                 pulse in the final cycle of each instruction
//   halted, illegal        sticky halt status
module multicycle_control
    import mc_pkg::*;
#(
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       halted,
    output logic       illegal
);

    logic [StateW-1:0] state_q, state_d;
    logic              illegal_q, illegal_d;

    iclass_t iclass;
    logic    op_illegal;

    mc_opdecode u_opdecode (
        .opcode  (opcode),
        .iclass  (iclass),
        .illegal (op_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (iclass)
                    ClsMem:    state_d = StMemAdr;
                    ClsRtype:  state_d = StExecR;
                    ClsItype:  state_d = StExecI;
                    ClsJal:    state_d = StJal;
                    ClsJalr:   state_d = StJalr;
                    ClsBranch: state_d = StBranch;
                    ClsLui:    state_d = StLui;
                    ClsAuipc:  state_d = StAuipc;
                    ClsFence:  state_d = StFetch;
                    ClsSystem: state_d = HALT_ON_SYSTEM ? StHalt : StFetch;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = op_illegal;
                    end
                endcase
            end
            StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR,
            StExecI,
            StLui,
            StAuipc,
            StJal,
            StLink:     state_d = StAluWb;
            StJalr:     state_d = StLink;
            StAluWb,
            StBranch:   state_d = StFetch;
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
    end

    // Ungated output decode; everything below is forced low while reset is held
    logic       mem_req_c, mem_we_c, adr_src_c, ir_write_c, reg_we_c, retire_c, halted_c;
    logic       pc_update, branch;
    logic [1:0] src_a_c, src_b_c, res_c, alu_op_c;

    always_comb begin
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        adr_src_c  = 1'b0;
        ir_write_c = 1'b0;
        reg_we_c   = 1'b0;
        retire_c   = 1'b0;
        halted_c   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        src_a_c    = SrcAPc;
        src_b_c    = SrcBRegB;
        res_c      = ResAluOut;
        alu_op_c   = AluAdd;
        case (state_q)
            StFetch: begin
                mem_req_c  = 1'b1;
                src_b_c    = SrcBFour;
                res_c      = ResAlu;
                ir_write_c = mem_ready;
                pc_update  = mem_ready;
            end
            StDecode: begin
                // ALUOut captures the branch/JAL target here
                src_a_c  = SrcAOldPc;
                src_b_c  = SrcBImm;
                retire_c = (iclass == ClsFence) ||
                           ((iclass == ClsSystem) && !HALT_ON_SYSTEM);
            end
            StMemAdr: begin
                src_a_c = SrcARegA;
                src_b_c = SrcBImm;
            end
            StMemRead: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            StMemWb: begin
                res_c    = ResData;
                reg_we_c = 1'b1;
                retire_c = 1'b1;
            end
            StMemWrite: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                retire_c  = mem_ready;
            end
            StExecR: begin
                src_a_c  = SrcARegA;
                alu_op_c = AluFunct;
            end
            StExecI: begin
                src_a_c  = SrcARegA;
                src_b_c  = SrcBImm;
                alu_op_c = AluFunct;
            end
            StLui: begin
                src_a_c = SrcAZero;
                src_b_c = SrcBImm;
            end
            StAuipc: begin
                src_a_c = SrcAOldPc;
                src_b_c = SrcBImm;
            end
            StJal: begin
                // PC loads the target held in ALUOut while the ALU forms OldPC + 4
                src_a_c   = SrcAOldPc;
                src_b_c   = SrcBFour;
                pc_update = 1'b1;
            end
            StJalr: begin
                src_a_c   = SrcARegA;
                src_b_c   = SrcBImm;
                res_c     = ResAlu;
                pc_update = 1'b1;
            end
            StLink: begin
                src_a_c = SrcAOldPc;
                src_b_c = SrcBFour;
            end
            StAluWb: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
            end
            StBranch: begin
                src_a_c  = SrcARegA;
                alu_op_c = AluBranch;
                branch   = 1'b1;
                retire_c = 1'b1;
            end
            StHalt: halted_c = 1'b1;
            default: ;
        endcase
    end

    // Gating with reset makes every output drop as soon as reset asserts,
    // even mid-cycle, so no enable can pulse after an abort.
    assign mem_req    = reset & mem_req_c;
    assign mem_we     = reset & mem_we_c;
    assign adr_src    = reset & adr_src_c;
    assign ir_write   = reset & ir_write_c;
    assign pc_we      = reset & (pc_update | (branch & br_cond));
    assign reg_we     = reset & reg_we_c;
    assign alu_src_a  = {2{reset}} & src_a_c;
    assign alu_src_b  = {2{reset}} & src_b_c;
    assign result_src = {2{reset}} & res_c;
    assign alu_op     = {2{reset}} & alu_op_c;
    assign retire     = reset & retire_c;
    assign halted     = reset & halted_c;
    assign illegal    = reset & illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       br_cond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_we, reg_we;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       retire, halted, illegal;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.HALT_ON_SYSTEM(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .br_cond    (br_cond),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .retire     (retire),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction classes of the reference model
    localparam int CLoad = 0, CStore = 1, CR = 2, CI = 3, CLui = 4, CAuipc = 5;
    localparam int CJal = 6, CJalr = 7, CBr = 8, CFence = 9;

    logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111};

    // Per-cycle snapshots of the last instruction, 1-based cycle index
    logic [1:0] s_a [64];
    logic [1:0] s_b [64];
    logic [1:0] s_rs [64];
    logic [1:0] s_aop [64];
    logic       s_pcwe [64];
    logic       s_regwe [64];
    bit         rdy_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {mem_req, mem_we, adr_src, ir_write, pc_we, reg_we, alu_src_a, alu_src_b,
                result_src, alu_op, retire, halted, illegal};
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later
    task automatic cyc(input logic [6:0] op, input logic rdy, input logic brc);
        @(negedge clk);
        opcode = op;
        mem_ready = rdy;
        br_cond = brc;
        #1;
        chk("we_onehot", 32'((int'(ir_write) + int'(reg_we) + int'(mem_we)) <= 1), 32'd1);
        chk("we_implies_req", 32'(!mem_we || mem_req), 32'd1);
    endtask

    function automatic int cls_of(input logic [6:0] op);
        for (int i = 0; i < 10; i++) if (ops[i] == op) return i;
        return -1;
    endfunction

    // Cycle count with no memory waits, straight from the instruction class
    function automatic int base_len(input int c);
        case (c)
            CFence:        return 2;
            CBr:           return 3;
            CLoad, CJalr:  return 5;
            default:       return 4;
        endcase
    endfunction

    // Reference model: an instruction is a list of phases; phase 0 (fetch) and
    // phase 3 of loads/stores wait for mem_ready, all others take one cycle.
    task automatic run_instr(input logic [6:0] op, input logic brc, input int mode,
                             output int ncyc);
        int   c, len, p, n;
        logic rdy, w, adv, last, wr_reg, pc_exp;
        c = cls_of(op);
        len = base_len(c);
        wr_reg = !(c == CStore || c == CBr || c == CFence);
        p = 0;
        n = 0;
        while (p < len && n < 60) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else rdy = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
            cyc(op, rdy, brc);
            n++;
            w = (p == 0) || ((c == CLoad || c == CStore) && p == 3);
            adv = !w || rdy;
            last = (p == len - 1) && adv;
            pc_exp = (p == 0 && rdy) || (p == 2 && (c == CJal || c == CJalr || (c == CBr && brc)));
            chk("mem_req", 32'(mem_req), 32'(w));
            chk("adr_src", 32'(adr_src), 32'(w && p == 3));
            chk("ir_write", 32'(ir_write), 32'(p == 0 && rdy));
            chk("mem_we", 32'(mem_we), 32'(c == CStore && p == 3));
            chk("reg_we", 32'(reg_we), 32'(last && wr_reg));
            chk("retire", 32'(retire), 32'(last));
            chk("pc_we", 32'(pc_we), 32'(pc_exp));
            chk("halted_run", 32'(halted), 32'd0);
            s_a[n] = alu_src_a;
            s_b[n] = alu_src_b;
            s_rs[n] = result_src;
            s_aop[n] = alu_op;
            s_pcwe[n] = pc_we;
            s_regwe[n] = reg_we;
            if (adv) p++;
        end
        chk("phases_done", 32'(p), 32'(len));
        ncyc = n;
    endtask

    initial begin
        int nc;
        // Reset state: everything gated low even with mem_ready high
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_fetch_req", 32'(mem_req), 32'd1);
        chk("rel_fetch_adr", 32'(adr_src), 32'd0);

        // add x3,x1,x2 with memory always ready
        run_instr(7'b0110011, 1'b0, 0, nc);
        chk("add_cycles", 32'(nc), 32'd4);
        chk("fetch_a", 32'(s_a[1]), 32'd0);
        chk("fetch_b", 32'(s_b[1]), 32'd2);
        chk("fetch_rs", 32'(s_rs[1]), 32'd2);
        chk("decode_a", 32'(s_a[2]), 32'd1);
        chk("decode_b", 32'(s_b[2]), 32'd1);
        chk("execr_aop", 32'(s_aop[3]), 32'd2);
        chk("execr_a", 32'(s_a[3]), 32'd2);
        chk("execr_b", 32'(s_b[3]), 32'd0);

        // lw: 2 waits in fetch, 3 in memread
        rdy_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(7'b0000011, 1'b0, 2, nc);
        chk("lw_cycles", 32'(nc), 32'd10);
        chk("lw_wb_rs", 32'(s_rs[10]), 32'd1);
        chk("lw_wb_we", 32'(s_regwe[10]), 32'd1);

        // beq taken / not taken
        run_instr(7'b1100011, 1'b1, 0, nc);
        chk("beq_t_cycles", 32'(nc), 32'd3);
        chk("beq_t_pcwe", 32'(s_pcwe[3]), 32'd1);
        chk("beq_aop", 32'(s_aop[3]), 32'd1);
        run_instr(7'b1100011, 1'b0, 0, nc);
        chk("beq_n_cycles", 32'(nc), 32'd3);
        chk("beq_n_pcwe", 32'(s_pcwe[3]), 32'd0);

        // jalr
        run_instr(7'b1100111, 1'b0, 0, nc);
        chk("jalr_cycles", 32'(nc), 32'd5);
        chk("jalr_pcwe", 32'(s_pcwe[3]), 32'd1);
        chk("jalr_rs", 32'(s_rs[3]), 32'd2);
        chk("link_a", 32'(s_a[4]), 32'd1);
        chk("link_b", 32'(s_b[4]), 32'd2);
        chk("jalr_wb", 32'(s_regwe[5]), 32'd1);

        // Unknown opcode halts with illegal set, sticky for 100 cycles
        cyc(7'h7F, 1'b1, 1'b0);
        cyc(7'h7F, 1'b1, 1'b0);
        chk("illeg_decode_retire", 32'(retire), 32'd0);
        for (int i = 0; i < 100; i++) begin
            cyc(7'b0110011, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_illegal", 32'(illegal), 32'd1);
            chk("halt_enables", 32'({mem_req, mem_we, ir_write, pc_we, reg_we, retire}), 32'd0);
        end
        #2 reset = 1'b0;
        #1;
        chk("halt_rst_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("halt_rel_req", 32'(mem_req), 32'd1);
        chk("halt_rel_adr", 32'(adr_src), 32'd0);
        chk("halt_rel_flags", 32'({halted, illegal}), 32'd0);

        // ECALL halts without flagging illegal
        cyc(7'b1110011, 1'b1, 1'b0);
        cyc(7'b1110011, 1'b1, 1'b0);
        cyc(7'b1110011, 1'b1, 1'b0);
        chk("ecall_halted", 32'(halted), 32'd1);
        chk("ecall_illegal", 32'(illegal), 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;

        // Reset during a MEMWRITE wait aborts at once
        cyc(7'b0100011, 1'b1, 1'b0);
        cyc(7'b0100011, 1'b1, 1'b0);
        cyc(7'b0100011, 1'b1, 1'b0);
        cyc(7'b0100011, 1'b0, 1'b0);
        chk("sw_wait_we", 32'(mem_we), 32'd1);
        cyc(7'b0100011, 1'b0, 1'b0);
        chk("sw_wait_retire", 32'(retire), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("sw_rst_outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        chk("sw_rst_hold", 32'(outs()), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("sw_rel_req", 32'(mem_req), 32'd1);
        chk("sw_rel_adr", 32'(adr_src), 32'd0);

        // Random legal instructions with random memory wait states
        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 1, nc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
